// File: rtl/uart_rx_frame_parser_if.sv
// rtl/uart_rx_frame_parser_if.sv - byte input and payload output handshake bundle
//
// Signals:
//   rx_data   [7:0]  received byte
//   rx_valid         one-cycle strobe qualifying rx_data
//   out_data  [7:0]  payload byte (0 while out_valid is low)
//   out_valid        payload byte available
//   out_ready        consumer accepts the byte
//   out_last         final payload byte of a frame
// Modports:
//   master  drives received bytes and out_ready (the environment side)
//   slave   the parser side

interface uart_rx_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;

    modport master (
        output rx_data,
        output rx_valid,
        output out_ready,
        input  out_data,
        input  out_valid,
        input  out_last
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  out_ready,
        output out_data,
        output out_valid,
        output out_last
    );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// rtl/uart_rx_frame_parser.sv - sync/length/payload/XOR-checksum frame parser
//
// Finds SYNC_BYTE, reads LEN and LEN payload bytes into a register buffer,
// checks CSUM = LEN ^ payload, and releases good payloads one byte at a time.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   bus         slave side of uart_rx_frame_parser_if (rx byte in, payload out)
//   frame_ok    one-cycle pulse, checksum matched
//   frame_err   one-cycle pulse, frame rejected
//   err_code    last error cause: 1 bad length, 2 checksum, 3 timeout
//   busy        high whenever the parser is not hunting for sync
//   drop_count  saturating count of bytes discarded while draining

module uart_rx_frame_parser #(
    parameter int         MAX_LEN        = 16,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    uart_rx_frame_parser_if.slave        bus,
    output logic                         frame_ok,
    output logic                         frame_err,
    output logic [1:0]                   err_code,
    output logic                         busy,
    output logic [7:0]                   drop_count
);
    localparam int         IW        = $clog2(MAX_LEN + 1);
    localparam int         GW        = $clog2(TIMEOUT_CYCLES + 1);
    // Depth rounded up to the full index range so every index value maps to
    // a real entry; entries beyond MAX_LEN are never written or read.
    localparam int         DEPTH     = 1 << IW;
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
    // The byte cycle itself counts as the first cycle of the gap, so the
    // error is registered at the end of idle cycle TIMEOUT_CYCLES-1 and is
    // visible exactly TIMEOUT_CYCLES cycles after the last accepted byte.
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CSUM, DRAIN} state_t;

    state_t          state;
    state_t          state_d;
    logic [IW-1:0]   len_q;
    logic [7:0]      csum_q;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic [GW-1:0]   gap_cnt;
    logic [7:0]      buf_mem [0:DEPTH-1];
    logic            out_valid_q;

    logic            frame_ok_d;
    logic            frame_err_d;
    logic [1:0]      err_code_d;

    logic            in_frame;
    logic            timeout_hit;
    logic            len_bad;
    logic            csum_match;
    logic            pay_last;
    logic            rd_last;
    logic            xfer;

    assign in_frame    = (state == LEN) || (state == PAYLOAD) || (state == CSUM);
    // A byte in the deadline cycle wins over the timeout.
    assign timeout_hit = in_frame && !bus.rx_valid && (gap_cnt == GAP_LAST);
    assign len_bad     = (bus.rx_data == 8'd0) || (bus.rx_data > MAX_LEN_B);
    assign csum_match  = (bus.rx_data == csum_q);
    assign pay_last    = ((wr_idx + IW'(1)) == len_q);
    assign rd_last     = ((rd_idx + IW'(1)) == len_q);
    assign xfer        = out_valid_q && bus.out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HUNT;
        end else begin
            state <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            HUNT: begin
                if (bus.rx_valid && (bus.rx_data == SYNC_BYTE)) begin
                    state_d = LEN;
                end
            end
            LEN: begin
                if (bus.rx_valid) begin
                    state_d = len_bad ? HUNT : PAYLOAD;
                end else if (timeout_hit) begin
                    state_d = HUNT;
                end
            end
            PAYLOAD: begin
                if (bus.rx_valid) begin
                    if (pay_last) begin
                        state_d = CSUM;
                    end
                end else if (timeout_hit) begin
                    state_d = HUNT;
                end
            end
            CSUM: begin
                if (bus.rx_valid) begin
                    state_d = csum_match ? DRAIN : HUNT;
                end else if (timeout_hit) begin
                    state_d = HUNT;
                end
            end
            DRAIN: begin
                if (xfer && rd_last) begin
                    state_d = HUNT;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Output decode (registered below)
    always_comb begin
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code;
        if (bus.rx_valid && (state == LEN) && len_bad) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd1;
        end
        if (bus.rx_valid && (state == CSUM)) begin
            if (csum_match) begin
                frame_ok_d  = 1'b1;
            end else begin
                frame_err_d = 1'b1;
                err_code_d  = 2'd2;
            end
        end
        if (timeout_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_ok    <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= 2'd0;
            busy        <= 1'b0;
            out_valid_q <= 1'b0;
            drop_count  <= 8'd0;
            len_q       <= '0;
            csum_q      <= 8'd0;
            wr_idx      <= '0;
            rd_idx      <= '0;
            gap_cnt     <= '0;
        end else begin
            frame_ok    <= frame_ok_d;
            frame_err   <= frame_err_d;
            err_code    <= err_code_d;
            busy        <= (state_d != HUNT);
            out_valid_q <= (state_d == DRAIN);

            if (bus.rx_valid || (state_d == HUNT) || (state_d == DRAIN)) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + GW'(1);
            end

            if (bus.rx_valid) begin
                case (state)
                    LEN: begin
                        // Truncation only matters for lengths that are rejected.
                        len_q  <= bus.rx_data[IW-1:0];
                        csum_q <= bus.rx_data;
                        wr_idx <= '0;
                    end
                    PAYLOAD: begin
                        csum_q <= csum_q ^ bus.rx_data;
                        wr_idx <= wr_idx + IW'(1);
                    end
                    CSUM: begin
                        rd_idx <= '0;
                    end
                    DRAIN: begin
                        if (drop_count != 8'hFF) begin
                            drop_count <= drop_count + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end

            if (xfer) begin
                rd_idx <= rd_idx + IW'(1);
            end
        end
    end

    // Payload storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if ((state == PAYLOAD) && bus.rx_valid) begin
            buf_mem[wr_idx] <= bus.rx_data;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_valid_q ? buf_mem[rd_idx] : 8'd0;
    assign bus.out_last  = out_valid_q && rd_last;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// tb/tb_uart_rx_frame_parser.sv - scoreboard bench for uart_rx_frame_parser

module tb_uart_rx_frame_parser;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_ok;
    logic       frame_err;
    logic [1:0] err_code;
    logic       busy;
    logic [7:0] drop_count;

    uart_rx_frame_parser_if bus ();

    uart_rx_frame_parser #(
        .MAX_LEN        (16),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (1024)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .frame_ok   (frame_ok),
        .frame_err  (frame_err),
        .err_code   (err_code),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         ok_cnt  = 0;
    int         err_cnt = 0;
    logic [8:0] exp_q [$];
    logic [8:0] sb_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every accepted output byte is checked against the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (frame_ok === 1'b1) ok_cnt++;
            if (frame_err === 1'b1) err_cnt++;
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_extra: out_data=%02h out_last=%0b, required no transfer",
                             bus.out_data, bus.out_last);
                end else begin
                    sb_e = exp_q.pop_front();
                    if ({bus.out_last, bus.out_data} !== sb_e) begin
                        n_fail++;
                        $display("FAIL sb_data: last/data=%0b/%02h, required %0b/%02h",
                                 bus.out_last, bus.out_data, sb_e[8], sb_e[7:0]);
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_not_busy(input string name);
        int k = 0;
        while (busy === 1'b1 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_drain_wait: busy=%0b, required 0 within 300 cycles", name, busy);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({bus.out_valid, bus.out_last, bus.out_data} !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%0b last=%0b data=%02h, required all 0",
                     bus.out_valid, bus.out_last, bus.out_data);
        end
        n_tests++;
        if ({frame_ok, frame_err, err_code} !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_status: ok=%0b err=%0b code=%0d, required all 0",
                     frame_ok, frame_err, err_code);
        end
        n_tests++;
        if ({busy, drop_count} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_busy_drop: busy=%0b drop=%0d, required 0/0", busy, drop_count);
        end
    endtask

    task automatic test_good_frame();
        int ok0 = ok_cnt;
        logic [7:0] s [8] = '{8'h00, 8'hFF, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        exp_q.push_back({1'b0, 8'h11});
        exp_q.push_back({1'b0, 8'h22});
        exp_q.push_back({1'b1, 8'h33});
        foreach (s[i]) send_byte(s[i]);
        n_tests++;
        if ({frame_ok, bus.out_valid, bus.out_data} !== {1'b1, 1'b1, 8'h11}) begin
            n_fail++;
            $display("FAIL good_first: ok=%0b valid=%0b data=%02h, required 1/1/11",
                     frame_ok, bus.out_valid, bus.out_data);
        end
        idle(3);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_busy: busy=%0b three cycles after CSUM+1, required 0", busy);
        end
        n_tests++;
        if (ok_cnt - ok0 != 1 || err_code !== 2'd0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL good_summary: ok pulses=%0d code=%0d left=%0d, required 1/0/0",
                     ok_cnt - ok0, err_code, exp_q.size());
        end
    endtask

    task automatic test_bad_checksum();
        logic [7:0] s [5] = '{8'hA5, 8'h02, 8'hAA, 8'h55, 8'h00};
        foreach (s[i]) send_byte(s[i]);
        n_tests++;
        if ({frame_err, frame_ok, err_code, bus.out_valid, busy} !== {1'b1, 1'b0, 2'd2, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bad_csum: err=%0b ok=%0b code=%0d valid=%0b busy=%0b, required 1/0/2/0/0",
                     frame_err, frame_ok, err_code, bus.out_valid, busy);
        end
        idle(2);
    endtask

    task automatic test_bad_len();
        send_byte(8'hA5);
        send_byte(8'h00);
        n_tests++;
        if ({frame_err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL len_zero: err=%0b code=%0d busy=%0b, required 1/1/0", frame_err, err_code, busy);
        end
        idle(1);
        send_byte(8'hA5);
        send_byte(8'h11);
        n_tests++;
        if ({frame_err, err_code, busy} !== {1'b1, 2'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL len_over: err=%0b code=%0d busy=%0b, required 1/1/0", frame_err, err_code, busy);
        end
        idle(1);
        exp_q.push_back({1'b1, 8'h5A});
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h5A);
        send_byte(8'h5B);
        n_tests++;
        if (frame_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL len_recover: ok=%0b, required 1", frame_ok);
        end
        wait_not_busy("len_recover");
    endtask

    task automatic test_max_len();
        logic [7:0] cs = 8'h10;
        logic [7:0] b;
        send_byte(8'hA5);
        send_byte(8'h10);
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 7 + 3);
            cs = cs ^ b;
            exp_q.push_back({(i == 15), b});
            send_byte(b);
        end
        send_byte(cs);
        n_tests++;
        if ({frame_ok, frame_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL max_len: ok=%0b err=%0b, required 1/0", frame_ok, frame_err);
        end
        wait_not_busy("max_len");
    endtask

    task automatic test_timeout();
        int k0;
        int n = 0;
        int e0;
        send_byte(8'hA5);
        send_byte(8'h02);
        k0 = cyc;
        send_byte(8'hAA);
        while (frame_err !== 1'b1 && n < 1100) begin
            @(posedge clk);
            #1;
            n++;
        end
        n_tests++;
        if (frame_err !== 1'b1 || cyc - k0 != 1024) begin
            n_fail++;
            $display("FAIL timeout_latency: err=%0b at offset %0d, required 1 at 1024",
                     frame_err, cyc - k0);
        end
        n_tests++;
        if ({err_code, busy} !== {2'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL timeout_code: code=%0d busy=%0b, required 3/0", err_code, busy);
        end
        idle(2);
        e0 = err_cnt;
        exp_q.push_back({1'b0, 8'hAA});
        exp_q.push_back({1'b1, 8'hBB});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        idle(1022);
        send_byte(8'hBB);
        n_tests++;
        if (frame_err !== 1'b0 || err_cnt != e0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_rescue: err=%0b pulses=%0d busy=%0b, required 0/0/1",
                     frame_err, err_cnt - e0, busy);
        end
        send_byte(8'h13);
        n_tests++;
        if (frame_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_rescue_ok: ok=%0b, required 1", frame_ok);
        end
        wait_not_busy("timeout_rescue");
    endtask

    task automatic test_backpressure();
        int bad = 0;
        bus.out_ready = 1'b0;
        exp_q.push_back({1'b0, 8'hC3});
        exp_q.push_back({1'b1, 8'h3C});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hC3);
        send_byte(8'h3C);
        send_byte(8'hFD);
        for (int i = 0; i < 50; i++) begin
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hC3 || bus.out_last !== 1'b0) bad++;
            if (i == 10 || i == 20 || i == 30) send_byte((i == 20) ? 8'hA5 : 8'h5A);
            else idle(1);
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_stable: %0d unstable cycles, required 0", bad);
        end
        n_tests++;
        if (drop_count !== 8'd3) begin
            n_fail++;
            $display("FAIL bp_drop: drop_count=%0d, required 3", drop_count);
        end
        bus.out_ready = 1'b1;
        wait_not_busy("bp");
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_drained: %0d bytes outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int ok0 = ok_cnt;
        logic [7:0] s [6] = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h03};
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b1, 8'h03});
        exp_q.push_back({1'b1, 8'h77});
        foreach (s[i]) send_byte(s[i]);
        idle(3);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_busy: busy=%0b, required 0", busy);
        end
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h77);
        send_byte(8'h76);
        n_tests++;
        if (frame_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_second: ok=%0b, required 1", frame_ok);
        end
        wait_not_busy("b2b");
        n_tests++;
        if (ok_cnt - ok0 != 2 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_summary: ok pulses=%0d left=%0d, required 2/0", ok_cnt - ok0, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, bus.out_valid, frame_ok, frame_err, err_code, drop_count} !== 13'd0) begin
            n_fail++;
            $display("FAIL rst_payload: busy=%0b valid=%0b ok=%0b err=%0b code=%0d drop=%0d, required all 0",
                     busy, bus.out_valid, frame_ok, frame_err, err_code, drop_count);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        bus.out_ready = 1'b0;
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'hE7);
        send_byte(8'hE6);
        n_tests++;
        if ({bus.out_valid, bus.out_data} !== {1'b1, 8'hE7}) begin
            n_fail++;
            $display("FAIL rst_drain_pre: valid=%0b data=%02h, required 1/E7", bus.out_valid, bus.out_data);
        end
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.out_valid, bus.out_data, bus.out_last, busy} !== 11'd0) begin
            n_fail++;
            $display("FAIL rst_drain: valid=%0b data=%02h last=%0b busy=%0b, required all 0",
                     bus.out_valid, bus.out_data, bus.out_last, busy);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        idle(1);
        exp_q.push_back({1'b0, 8'h10});
        exp_q.push_back({1'b1, 8'h20});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h32);
        n_tests++;
        if (frame_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_recover: ok=%0b, required 1", frame_ok);
        end
        wait_not_busy("rst_recover");
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.rx_valid  = 1'b0;
        bus.rx_data   = 8'h00;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_bad_len();
        test_max_len();
        test_timeout();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: %0d bytes never delivered, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
